rb_steer_pipe: RTL and testbench

RB_STEER_PIPE -- requirements
Module: rb_steer_pipe

---
 rtl/rb_steer_pipe.sv | 118 +++++++++++
 tb/tb_rb_steer_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rb_steer_pipe.sv
// rb_steer_pipe: single-register-stage row-buffer lane rotator.
// Each accepted beat carries one pixel per row buffer. The output lanes are
// rotated by a pointer that advances once per image row, so the oldest row
// always appears on lane 0. An in_sof beat restarts the rotation at 0.
// Optional feature macro: RB_STEER_EOL_EN adds out_eol, which flags the
// last column of a row and travels with out_data.
module rb_steer_pipe #(
  parameter int PIXEL_WIDTH = 8,
  parameter int RBs         = 3,
  parameter int RB_ADDR     = 2,
  parameter int IMG_WIDTH   = 640,
  parameter int COL_ADDR    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RBs*PIXEL_WIDTH-1:0] in_data,
  input  logic                       in_sof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RBs*PIXEL_WIDTH-1:0] out_data,
  output logic [RB_ADDR-1:0]         rot
`ifdef RB_STEER_EOL_EN
  ,
  output logic                       out_eol
`endif
);

  localparam int DW = RBs * PIXEL_WIDTH;

  logic              r_valid;
  logic [DW-1:0]     r_data;
  logic [RB_ADDR-1:0] r_rot;
  logic [COL_ADDR-1:0] r_col;

  logic               w_accept;
  logic [RB_ADDR-1:0] w_rot_eff;
  logic [RB_ADDR-1:0] w_rot_inc;
  logic [RB_ADDR-1:0] w_rot_next;
  logic [COL_ADDR-1:0] w_beat_col;
  logic [COL_ADDR-1:0] w_col_next;
  logic               w_last_col;
  logic [DW-1:0]      w_rot_data;

  // The single output register may be refilled whenever it is empty or
  // being drained in the same cycle.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // A start-of-frame beat is column 0 with rotation 0, regardless of the
  // position the previous frame left behind.
  assign w_rot_eff  = in_sof ? '0 : r_rot;
  assign w_beat_col = in_sof ? '0 : r_col;
  assign w_last_col = (w_beat_col == COL_ADDR'(IMG_WIDTH - 1));

  assign w_rot_inc  = (r_rot == RB_ADDR'(RBs - 1)) ? '0 : r_rot + RB_ADDR'(1);
  // sof beats are column 0, so they never coincide with a row wrap here.
  assign w_rot_next = in_sof ? '0 : (w_last_col ? w_rot_inc : r_rot);
  assign w_col_next = w_last_col ? '0 : w_beat_col + COL_ADDR'(1);

  // Per-lane selector: output lane gi takes input lane (gi + rotation) mod RBs.
  genvar gi;
  generate
    for (gi = 0; gi < RBs; gi++) begin : g_lane
      logic [PIXEL_WIDTH-1:0] w_pick;

      // Select the source lane for this output lane from the effective rotation.
      always_comb begin
        w_pick = in_data[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
        for (int k = 1; k < RBs; k++) begin
          if (w_rot_eff == RB_ADDR'(k)) begin
            w_pick = in_data[((gi + k) % RBs)*PIXEL_WIDTH +: PIXEL_WIDTH];
          end
        end
      end

      assign w_rot_data[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = w_pick;
    end
  endgenerate

  // Output register plus row position; everything holds unless a beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rot   <= '0;
      r_col   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_rot_data;
      r_rot   <= w_rot_next;
      r_col   <= w_col_next;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef RB_STEER_EOL_EN
  logic r_eol;

  // End-of-line flag registered alongside the pixel column it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_eol <= 1'b0;
    end else if (w_accept) begin
      r_eol <= w_last_col;
    end
  end

  assign out_eol = r_eol;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign rot       = r_rot;

endmodule

// File: tb/tb_rb_steer_pipe.sv
// Testbench for rb_steer_pipe (RBs=3, PIXEL_WIDTH=8, IMG_WIDTH=4).
// Directed scenarios with known constants, then a randomized run compared
// against a behavioural model of the rotation/row rules.
module tb_rb_steer_pipe;
  localparam int PW  = 8;
  localparam int RBS = 3;
  localparam int RBA = 2;
  localparam int W   = 4;
  localparam int CA  = 3;
  localparam int DW  = RBS * PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [RBA-1:0] rot;
`ifdef RB_STEER_EOL_EN
  logic          out_eol;
`endif

  rb_steer_pipe #(
    .PIXEL_WIDTH(PW),
    .RBs        (RBS),
    .RB_ADDR    (RBA),
    .IMG_WIDTH  (W),
    .COL_ADDR   (CA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .rot      (rot)
`ifdef RB_STEER_EOL_EN
    ,
    .out_eol  (out_eol)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: what the block should be holding after each edge.
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_eol   = 1'b0;
  int            m_rot   = 0;
  int            m_col   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rotate(input logic [DW-1:0] d, input int r);
    logic [DW-1:0] o;
    for (int i = 0; i < RBS; i++) begin
      o[i*PW +: PW] = d[((i + r) % RBS)*PW +: PW];
    end
    return o;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check in_ready,
  // advance the model on the rising edge and check the registered outputs.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit s, input bit ordy,
                      input string tag);
    bit acc;
    int bc;
    in_valid  = v;
    in_data   = d;
    in_sof    = s;
    out_ready = ordy;
    #1;
    if (rst_n) check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
    acc = v && (!m_valid || ordy);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_eol = 1'b0; m_rot = 0; m_col = 0;
    end else if (acc) begin
      bc      = s ? 0 : m_col;
      m_data  = rotate(d, s ? 0 : m_rot);
      m_valid = 1'b1;
      m_eol   = (bc == W - 1);
      if (s) m_rot = 0;
      if (bc == W - 1) begin
        m_col = 0;
        m_rot = (m_rot + 1) % RBS;
      end else begin
        m_col = bc + 1;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".out_data"}, 32'(out_data), 32'(m_data));
    check({tag, ".rot"}, 32'(rot), 32'(m_rot));
`ifdef RB_STEER_EOL_EN
    check({tag, ".eol"}, 32'(out_eol), 32'(m_eol));
`endif
    @(negedge clk);
  endtask

  localparam logic [DW-1:0] PAT    = 24'h332211;
  localparam logic [DW-1:0] PAT_R1 = 24'h113322;
  localparam logic [DW-1:0] PAT_R2 = 24'h221133;

  initial begin
    logic [DW-1:0] exp_tab [3];
    logic [DW-1:0] held;
    exp_tab[0] = PAT; exp_tab[1] = PAT_R1; exp_tab[2] = PAT_R2;

    // Reset state
    rst_n = 1'b0;
    step(0, '0, 0, 1, "reset");
    check("reset.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // 12-beat stream from sof: rotation advances every 4 beats and wraps
    for (int n = 1; n <= 12; n++) begin
      step(1, PAT, n == 1, 1, "stream");
      check("stream.data_const", 32'(out_data), 32'(exp_tab[((n - 1) / 4) % 3]));
      if (n == 4)  check("stream.rot_after4", 32'(rot), 32'd1);
      if (n == 12) check("stream.rot_wrap", 32'(rot), 32'd0);
`ifdef RB_STEER_EOL_EN
      check("stream.eol_const", 32'(out_eol), 32'((n % 4) == 0));
`endif
    end
    step(1, PAT, 0, 1, "stream13");
    check("stream13.data_const", 32'(out_data), 32'(PAT));

    // Backpressure for 3 cycles: output and row position hold
    held = out_data;
    for (int n = 0; n < 3; n++) begin
      step(1, 24'hA0B0C0, 0, 0, "stall");
      check("stall.in_ready_const", 32'(in_ready), 32'd0);
      check("stall.hold", 32'(out_data), 32'(held));
    end
    step(1, 24'hA0B0C0, 0, 1, "release");
    step(0, '0, 0, 1, "drain");
    check("drain.valid_const", 32'(out_valid), 32'd0);

    // sof at column 2 while rot=2
    step(1, PAT, 1, 1, "sofmid");
    for (int n = 2; n <= 10; n++) step(1, PAT, 0, 1, "sofmid");
    check("sofmid.rot2", 32'(rot), 32'd2);
    step(1, PAT, 1, 1, "sofmid.sof");
    check("sofmid.sof_data", 32'(out_data), 32'(PAT));
    check("sofmid.sof_rot", 32'(rot), 32'd0);
    for (int n = 0; n < 3; n++) step(1, PAT, 0, 1, "sofmid.after");
    check("sofmid.col1_rot", 32'(rot), 32'd1);

    // sof ignored while not accepted
    step(0, PAT, 1, 1, "sof_novalid");
    check("sof_novalid.rot", 32'(rot), 32'd1);

    // Reset mid-row with rot=1 and out_valid=1
    step(1, PAT, 0, 0, "prereset");
    rst_n = 1'b0;
    step(1, PAT, 0, 1, "midreset");
    rst_n = 1'b1;
    check("midreset.valid_const", 32'(out_valid), 32'd0);
    check("midreset.rot_const", 32'(rot), 32'd0);
    step(0, '0, 0, 1, "postreset");

    // Randomized traffic including sof, backpressure and occasional reset
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7, "rand");
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
